// File: rtl/imm_pkg.sv
// Shared immediate-format definitions used by both the decode-side extractor and
// the encode-side scatter logic.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_src_e;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_entry_t;

  // True when v[31:msb] are all equal, i.e. v survives truncation to msb+1 bits
  // followed by sign extension.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] s;
    s = $signed(v) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational immediate scatter into RISC-V I/S/B/J/U positions, with
// range and alignment checking. Non-immediate bits pass through from base.
module imm_scatter
  import imm_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output enc_entry_t  entry
);

  always_comb begin
    entry.inst = base;
    entry.err  = 1'b0;
    case (imm_src)
      IMM_I: begin
        entry.inst[31:20] = imm[11:0];
        entry.err         = !sext_fits(imm, 11);
      end
      IMM_S: begin
        entry.inst[31:25] = imm[11:5];
        entry.inst[11:7]  = imm[4:0];
        entry.err         = !sext_fits(imm, 11);
      end
      IMM_B: begin
        entry.inst[31]    = imm[12];
        entry.inst[7]     = imm[11];
        entry.inst[30:25] = imm[10:5];
        entry.inst[11:8]  = imm[4:1];
        entry.err         = !sext_fits(imm, 12) || imm[0];
      end
      IMM_J: begin
        entry.inst[31]    = imm[20];
        entry.inst[19:12] = imm[19:12];
        entry.inst[20]    = imm[11];
        entry.inst[30:21] = imm[10:1];
        entry.err         = !sext_fits(imm, 20) || imm[0];
      end
      IMM_U: begin
        entry.inst[31:12] = imm[31:12];
        entry.err         = |imm[11:0];
      end
      // Illegal format: instruction passes through untouched, flagged as error.
      default: entry.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_inst_encoder.sv
// Immediate encoder with output FIFO and saturating statistics counters.
// Optional macro IMM_ENC_ERR_DROP_EN: errored requests are counted but not queued.
module imm_inst_encoder
  import imm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      Imm,
  input  logic [31:0]      BaseInst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      InstOut,
  output logic             ImmErr,
  output logic [CNT_W-1:0] EncCnt,
  output logic [CNT_W-1:0] ErrCnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  enc_entry_t    mem [DEPTH];
  enc_entry_t    enc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          accept, push, pop;

  imm_scatter u_scatter (
    .imm_src (ImmSrc),
    .imm     (Imm),
    .base    (BaseInst),
    .entry   (enc)
  );

  // in_ready depends only on registered occupancy: no pass-through path.
  assign in_ready  = (count < FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign InstOut   = out_valid ? mem[rd_ptr].inst : '0;

`ifdef IMM_ENC_ERR_DROP_EN
  assign push   = accept && !enc.err;
  assign ImmErr = 1'b0;
`else
  assign push   = accept;
  assign ImmErr = out_valid ? mem[rd_ptr].err : 1'b0;
`endif

  // Storage needs no reset: reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EncCnt <= '0;
      ErrCnt <= '0;
    end else if (accept) begin
      if (!enc.err && EncCnt != '1) EncCnt <= EncCnt + 1'b1;
      if (enc.err && ErrCnt != '1)  ErrCnt <= ErrCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench for imm_inst_encoder: directed vector table, handshake and
// reset sequences, then randomized traffic against a decode-side extraction model.
module tb_imm_inst_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef IMM_ENC_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       ImmSrc = '0;
  logic [31:0]      Imm = '0;
  logic [31:0]      BaseInst = '0;
  logic             in_ready, out_valid, ImmErr;
  logic [31:0]      InstOut;
  logic [CNT_W-1:0] EncCnt, ErrCnt;

  imm_inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmSrc    (ImmSrc),
    .Imm       (Imm),
    .BaseInst  (BaseInst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .InstOut   (InstOut),
    .ImmErr    (ImmErr),
    .EncCnt    (EncCnt),
    .ErrCnt    (ErrCnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_enc = 0;
  int exp_err = 0;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
  } req_t;

  vec_t tbl[10];
  req_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Decode-side extraction, as the core would see the instruction.
  function automatic logic [31:0] extract(input logic [2:0] src, input logic [31:0] i);
    case (src)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'b0};
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(input logic [2:0] src);
    case (src)
      3'd0:      return 32'hFFF0_0000;
      3'd1, 3'd2: return 32'hFE00_0F80;
      default:   return 32'hFFFF_F000;
    endcase
  endfunction

  // Value the format can actually carry: sign-truncate and drop bit 0 where aligned.
  function automatic logic [31:0] trunc(input logic [2:0] src, input logic [31:0] imm);
    int t;
    case (src)
      3'd0, 3'd1: begin t = $signed(imm << 20); return 32'(t >>> 20); end
      3'd2:       begin t = $signed(imm << 19); return 32'(t >>> 19) & ~32'd1; end
      3'd3:       begin t = $signed(imm << 11); return 32'(t >>> 11) & ~32'd1; end
      default:    return imm & 32'hFFFF_F000;
    endcase
  endfunction

  function automatic logic model_err(input logic [2:0] src, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (src)
      3'd0, 3'd1: return (v < -2048) || (v > 2047);
      3'd2:       return (v < -4096) || (v > 4095) || (v % 2 != 0);
      3'd3:       return (v < -(1 << 20)) || (v > (1 << 20) - 1) || (v % 2 != 0);
      3'd4:       return (imm % 4096) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic int sat(input int n);
    return (n > MAXC) ? MAXC : n;
  endfunction

  task automatic count_accept(input logic e);
    if (e) exp_err = sat(exp_err + 1);
    else   exp_enc = sat(exp_enc + 1);
  endtask

  task automatic check_head(input req_t r);
    logic [31:0] m;
    m = imm_mask(r.src);
    if (r.src <= 3'd4) begin
      chk("rnd imm", extract(r.src, InstOut), trunc(r.src, r.imm));
      chk("rnd base bits", InstOut & ~m, r.base & ~m);
    end else begin
      chk("rnd illegal inst", InstOut, r.base);
    end
    chk("rnd err", {31'b0, ImmErr}, {31'b0, model_err(r.src, r.imm) && !DROP});
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
    in_valid = 1'b1; ImmSrc = s; Imm = i; BaseInst = b;
  endtask

  function automatic req_t gen_req();
    req_t r;
    int   p, v;
    p = $urandom_range(0, 99);
    r.base = $urandom;
    if (p < 10) begin
      r.src = 3'($urandom_range(5, 7));
      r.imm = $urandom;
    end else begin
      r.src = 3'($urandom_range(0, 4));
      if (p < 25) r.imm = $urandom;
      else begin
        case (r.src)
          3'd0, 3'd1: v = $urandom_range(0, 4095) - 2048;
          3'd2:       v = ($urandom_range(0, 4095) - 2048) * 2;
          3'd3:       v = ($urandom_range(0, (1 << 20) - 1) - (1 << 19)) * 2;
          default:    v = $urandom & 32'hFFFF_F000;
        endcase
        r.imm = 32'(v);
      end
    end
    return r;
  endfunction

  initial begin
    tbl[0] = '{3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0};
    tbl[1] = '{3'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0};
    tbl[2] = '{3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1};
    tbl[3] = '{3'd3, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1};
    tbl[4] = '{3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0};
    tbl[5] = '{3'd1, 32'h0000_07FF, 32'h0000_0023, 32'h7E00_0FA3, 1'b0};
    tbl[6] = '{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    tbl[7] = '{3'd5, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    tbl[8] = '{3'd3, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0};
    tbl[9] = '{3'd4, 32'h0000_0800, 32'h0000_0037, 32'h0000_0037, 1'b1};

    #2 rst_n = 1'b0;
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 0);
    chk("reset InstOut", InstOut, 0);
    chk("reset ImmErr", {31'b0, ImmErr}, 0);
    chk("reset EncCnt", 32'(EncCnt), 0);
    chk("reset ErrCnt", 32'(ErrCnt), 0);
    chk("reset in_ready", {31'b0, in_ready}, 1);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors, one request at a time with the consumer always ready.
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("tbl in_ready", {31'b0, in_ready}, 1);
      drive(tbl[k].src, tbl[k].imm, tbl[k].base);
      @(negedge clk);
      in_valid = 1'b0;
      count_accept(tbl[k].err);
      if (DROP && tbl[k].err) begin
        chk("tbl dropped", {31'b0, out_valid}, 0);
      end else begin
        chk("tbl out_valid", {31'b0, out_valid}, 1);
        chk("tbl InstOut", InstOut, tbl[k].inst);
        chk("tbl ImmErr", {31'b0, ImmErr}, {31'b0, tbl[k].err && !DROP});
      end
      chk("tbl EncCnt", 32'(EncCnt), 32'(exp_enc));
      chk("tbl ErrCnt", 32'(ErrCnt), 32'(exp_err));
    end

    // Backpressure: three requests into a two-entry FIFO.
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'd4, 32'h1111_1000, 32'h0000_0037);
    @(negedge clk);
    chk("bp lat out_valid", {31'b0, out_valid}, 1);
    chk("bp in_ready 1", {31'b0, in_ready}, 1);
    drive(3'd4, 32'h2222_2000, 32'h0000_0037);
    @(negedge clk);
    drive(3'd4, 32'h3333_3000, 32'h0000_0037);
    for (int k = 0; k < 3; k++) begin
      chk("bp full in_ready", {31'b0, in_ready}, 0);
      chk("bp head hold", InstOut, 32'h1111_1037);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp drain 2", InstOut, 32'h2222_2037);
    chk("bp in_ready back", {31'b0, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp drain 3", InstOut, 32'h3333_3037);
    @(negedge clk);
    chk("bp empty", {31'b0, out_valid}, 0);
    for (int k = 0; k < 3; k++) count_accept(1'b0);
    chk("bp EncCnt", 32'(EncCnt), 32'(exp_enc));

    // Asynchronous reset with two buffered entries.
    out_ready = 1'b0;
    drive(3'd4, 32'hAAAA_A000, 32'h0000_0037);
    @(negedge clk);
    drive(3'd4, 32'hBBBB_B000, 32'h0000_0037);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst pre full", {31'b0, in_ready}, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_enc = 0;
    exp_err = 0;
    chk("rst out_valid", {31'b0, out_valid}, 0);
    chk("rst InstOut", InstOut, 0);
    chk("rst EncCnt", 32'(EncCnt), 0);
    chk("rst ErrCnt", 32'(ErrCnt), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst no stale beat", {31'b0, out_valid}, 0);
    end

    // Randomized traffic; queue q models FIFO contents, counters saturate at CNT_W.
    for (int c = 0; c < 10000; c++) begin
      req_t r;
      chk("rnd out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("rnd in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
      if (out_valid && q.size() != 0) check_head(q[0]);
      if (c % 100 == 0) begin
        chk("rnd EncCnt", 32'(EncCnt), 32'(exp_enc));
        chk("rnd ErrCnt", 32'(ErrCnt), 32'(exp_err));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      r = gen_req();
      if ($urandom_range(0, 3) != 0) drive(r.src, r.imm, r.base);
      else in_valid = 1'b0;
      if (in_valid && in_ready) begin
        count_accept(model_err(r.src, r.imm));
        if (!(DROP && model_err(r.src, r.imm))) q.push_back(r);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("final EncCnt", 32'(EncCnt), 32'(exp_enc));
    chk("final ErrCnt", 32'(ErrCnt), 32'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_inst_encoder.md
Name: imm_inst_encoder

Overview:
- Inverse of the core's decode-side immediate extraction. Takes a 32-bit immediate, an immediate-format select and a base instruction word, then scatters the immediate into the RISC-V I/S/B/J/U bit positions.
- Range-checks and alignment-checks every immediate before encoding.
- Buffers results in a small output FIFO with valid/ready handshakes on both sides.
- Sits between the self-test program generator and the instruction-memory write port.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- ImmSrc  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, others illegal.
- Imm  in  32  byte-offset/value immediate to encode.
- BaseInst  in  32  instruction carrying opcode/rd/rs/funct fields; its immediate bit positions are overwritten.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  consumer takes the head when out_valid && out_ready.
- InstOut  out  32  encoded instruction at the FIFO head; 0 when empty.
- ImmErr  out  1  error flag of the head entry; 0 when empty.
- EncCnt  out  CNT_W  count of accepted requests without error.
- ErrCnt  out  CNT_W  count of accepted requests with error.

Behaviour:
- Reset (asynchronous, rst_n=0): FIFO flushed, pointers 0, out_valid=0, InstOut=0, ImmErr=0, EncCnt=0, ErrCnt=0. Reset mid-operation discards all buffered entries.
- Encoding is combinational on the accepted request. The result {InstOut, ImmErr} is written into the FIFO on the accept edge.
  - Bits not listed below are copied from BaseInst.
  - I: Inst[31:20]=Imm[11:0]. Error unless Imm[31:11] are all equal.
  - S: Inst[31:25]=Imm[11:5], Inst[11:7]=Imm[4:0]. Same range rule as I.
  - B: Inst[31]=Imm[12], Inst[7]=Imm[11], Inst[30:25]=Imm[10:5], Inst[11:8]=Imm[4:1]. Error unless Imm[31:12] are all equal and Imm[0]=0.
  - J: Inst[31]=Imm[20], Inst[19:12]=Imm[19:12], Inst[20]=Imm[11], Inst[30:21]=Imm[10:1]. Error unless Imm[31:20] are all equal and Imm[0]=0.
  - U: Inst[31:12]=Imm[31:12]. Error unless Imm[11:0]=0.
  - Illegal ImmSrc: InstOut=BaseInst, error=1.
  - On an error, the written InstOut is still the bit-scatter result; the truncated or misaligned bits are simply lost.
- Round-trip property: for every error-free entry, re-extracting the immediate from InstOut with ImmSrc returns Imm exactly.
- Handshake:
  - in_ready = (count < DEPTH), combinational from registered count only. There is no same-cycle pass-through.
  - Minimum latency is 1 cycle: accept at edge N gives out_valid=1 after edge N.
  - out_valid = (count != 0). The head is held stable while out_valid && !out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - When full, in_ready=0 regardless of out_ready.
  - Read and write pointers wrap modulo DEPTH.
- Counters:
  - EncCnt increments on each error-free accept; ErrCnt increments on each errored accept.
  - Both saturate at all-ones, with no wrap.
  - Both update on the accept edge regardless of FIFO drain.

Optional Feature:
- Macro IMM_ENC_ERR_DROP_EN.
- Defined: errored requests are accepted and counted in ErrCnt but never written into the FIFO. ImmErr is then tied to 0.
- Undefined: errored requests are written to the FIFO with ImmErr=1.
- in_ready is the same in both builds.

Decomposition:
- Shared package imm_pkg holds:
  - typedef enum imm_src_e {IMM_I=3'b000, IMM_S, IMM_B, IMM_J, IMM_U}, shared with the decode-side immediate logic;
  - a packed struct enc_entry_t {logic [31:0] inst; logic err;}.
- One sub-module is natural: imm_scatter. It is a pure combinational encoder plus range/alignment checker.
- The FIFO, handshake and counters stay in the top module.

Test Plan:
- I-type: ImmSrc=000, Imm=32'hFFFF_F800 (-2048), BaseInst=32'h0000_0013, out_ready=1 -> InstOut=32'h8000_0013, ImmErr=0 one cycle later; EncCnt=1.
- B-type: ImmSrc=010, Imm=32'h0000_0FFE, BaseInst=32'h0000_0063 -> InstOut=32'h7E00_0FE3, ImmErr=0. Same request with Imm=32'h0000_0003 -> ImmErr=1, ErrCnt=1 (with IMM_ENC_ERR_DROP_EN: no output beat, ErrCnt=1).
- J/U range: ImmSrc=011, Imm=32'h0010_0000 -> ImmErr=1. ImmSrc=100, Imm=32'h1234_5000, BaseInst=32'h0000_0037 -> InstOut=32'h1234_5037, ImmErr=0.
- Backpressure: out_ready=0, three back-to-back requests with DEPTH=2 -> in_ready drops after 2 accepts. Then out_ready=1 -> entries drain in order, in_ready returns.
- Reset mid-operation: FIFO holding 2 entries, pulse rst_n low asynchronously -> out_valid=0, InstOut=0, counters 0 immediately, and no stale beat after release.
- Randomized round-trip: 10k legal random Imm/ImmSrc -> the bench extraction model reproduces Imm for every beat; illegal ImmSrc=101..111 -> InstOut=BaseInst, ImmErr=1.
